// File: rtl/iob_pcie_chnl_drv_pkg.sv
// Shared state encodings and beat sizing for the RIFFA-style channel driver.
// Optional ACK timeout is enabled by defining IOB_PCIE_CHNL_DRV_TIMEOUT_EN.
package iob_pcie_chnl_drv_pkg;

    typedef enum logic [1:0] {
        O_IDLE = 2'd0,
        O_REQ  = 2'd1,
        O_DATA = 2'd2
    } o_state_t;

    typedef enum logic [1:0] {
        I_IDLE = 2'd0,
        I_ACK  = 2'd1,
        I_DATA = 2'd2,
        I_DONE = 2'd3
    } i_state_t;

    // Number of 32-bit words carried by one data-bus beat.
    function automatic int beat_words(input int data_width);
        return data_width / 32;
    endfunction

endpackage

// File: rtl/iob_pcie_chnl_wcnt.sv
// Transfer word counter: clears at transfer start, advances by one beat's
// worth of words, and flags the beat that reaches or passes the length.
module iob_pcie_chnl_wcnt #(
    parameter int LEN_W = 32,
    parameter int INC   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             beat,
    input  logic [LEN_W-1:0] len,
    output logic             hit
);

    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W:0]   sum;

    // One extra bit keeps the sum from wrapping before the compare.
    assign sum = {1'b0, cnt_q} + (LEN_W+1)'(INC);
    assign hit = (sum >= {1'b0, len});

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (beat) begin
            cnt_d = sum[LEN_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/iob_pcie_chnl_drv.sv
// Channel driver: independent outbound (command/stream -> CHNL_RX) and inbound
// (CHNL_TX -> stream) engines. IOB_PCIE_CHNL_DRV_TIMEOUT_EN adds an ACK timeout.
module iob_pcie_chnl_drv
    import iob_pcie_chnl_drv_pkg::*;
#(
    parameter int C_PCI_DATA_WIDTH = 64,
    parameter int LEN_W            = 32,
    parameter int OFF_W            = 31,
    parameter int ACK_TIMEOUT      = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [LEN_W-1:0]            cmd_len,
    input  logic [OFF_W-1:0]            cmd_off,
    input  logic                        cmd_last,
    input  logic [C_PCI_DATA_WIDTH-1:0] s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic [C_PCI_DATA_WIDTH-1:0] m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [LEN_W-1:0]            done_len,
    output logic                        done_pulse,
    output logic                        err_timeout,
    output logic                        CHNL_RX,
    input  logic                        CHNL_RX_ACK,
    output logic                        CHNL_RX_LAST,
    output logic [LEN_W-1:0]            CHNL_RX_LEN,
    output logic [OFF_W-1:0]            CHNL_RX_OFF,
    output logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
    output logic                        CHNL_RX_DATA_VALID,
    input  logic                        CHNL_RX_DATA_REN,
    input  logic                        CHNL_TX,
    output logic                        CHNL_TX_ACK,
    input  logic                        CHNL_TX_LAST,
    input  logic [LEN_W-1:0]            CHNL_TX_LEN,
    input  logic [OFF_W-1:0]            CHNL_TX_OFF,
    input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA,
    input  logic                        CHNL_TX_DATA_VALID,
    output logic                        CHNL_TX_DATA_REN
);

    localparam int INC = beat_words(C_PCI_DATA_WIDTH);

    o_state_t         o_state_q, o_state_d;
    logic [LEN_W-1:0] o_len_q, o_len_d;
    logic [OFF_W-1:0] o_off_q, o_off_d;
    logic             o_last_q, o_last_d;
    logic             o_clr, o_beat, o_hit, o_tmo;

    i_state_t         i_state_q, i_state_d;
    logic [LEN_W-1:0] i_len_q, i_len_d;
    logic [LEN_W-1:0] done_len_q, done_len_d;
    logic             tx_armed_q, tx_armed_d;
    logic             i_clr, i_beat, i_hit;

    // Inbound offset/last are informational only for this sink.
    logic unused_tx_hdr;
    assign unused_tx_hdr = ^{CHNL_TX_LAST, CHNL_TX_OFF};

    iob_pcie_chnl_wcnt #(.LEN_W(LEN_W), .INC(INC)) u_o_wcnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (o_clr),
        .beat (o_beat),
        .len  (o_len_q),
        .hit  (o_hit)
    );

    iob_pcie_chnl_wcnt #(.LEN_W(LEN_W), .INC(INC)) u_i_wcnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (i_clr),
        .beat (i_beat),
        .len  (i_len_q),
        .hit  (i_hit)
    );

`ifdef IOB_PCIE_CHNL_DRV_TIMEOUT_EN
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;

    assign o_tmo = (o_state_q == O_REQ) && !CHNL_RX_ACK &&
                   (tmo_q == TMO_W'(ACK_TIMEOUT));

    always_comb begin
        tmo_d = '0;
        err_d = err_q;
        if (o_state_q == O_REQ) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
        if (o_tmo) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    localparam int unused_ack_timeout = ACK_TIMEOUT;

    assign o_tmo       = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        o_state_d          = o_state_q;
        o_len_d            = o_len_q;
        o_off_d            = o_off_q;
        o_last_d           = o_last_q;
        o_clr              = 1'b0;
        o_beat             = 1'b0;
        cmd_ready          = 1'b0;
        CHNL_RX            = 1'b0;
        CHNL_RX_DATA_VALID = 1'b0;
        s_ready            = 1'b0;
        case (o_state_q)
            O_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    o_len_d   = cmd_len;
                    o_off_d   = cmd_off;
                    o_last_d  = cmd_last;
                    o_clr     = 1'b1;
                    o_state_d = O_REQ;
                end
            end
            O_REQ: begin
                CHNL_RX = 1'b1;
                if (CHNL_RX_ACK) begin
                    o_state_d = (o_len_q == '0) ? O_IDLE : O_DATA;
                end else if (o_tmo) begin
                    o_state_d = O_IDLE;
                end
            end
            O_DATA: begin
                CHNL_RX            = 1'b1;
                CHNL_RX_DATA_VALID = s_valid;
                s_ready            = CHNL_RX_DATA_REN;
                o_beat             = s_valid & CHNL_RX_DATA_REN;
                if (o_beat && o_hit) begin
                    o_state_d = O_IDLE;
                end
            end
            default: o_state_d = O_IDLE;
        endcase
    end

    always_comb begin
        i_state_d        = i_state_q;
        i_len_d          = i_len_q;
        done_len_d       = done_len_q;
        tx_armed_d       = tx_armed_q | ~CHNL_TX;
        i_clr            = 1'b0;
        i_beat           = 1'b0;
        CHNL_TX_ACK      = 1'b0;
        CHNL_TX_DATA_REN = 1'b0;
        m_valid          = 1'b0;
        done_pulse       = 1'b0;
        case (i_state_q)
            I_IDLE: begin
                // A request still high from the last transfer must drop first.
                if (CHNL_TX && tx_armed_q) begin
                    i_len_d    = CHNL_TX_LEN;
                    i_clr      = 1'b1;
                    tx_armed_d = 1'b0;
                    i_state_d  = I_ACK;
                end
            end
            I_ACK: begin
                CHNL_TX_ACK = 1'b1;
                i_state_d   = (i_len_q == '0) ? I_DONE : I_DATA;
            end
            I_DATA: begin
                CHNL_TX_DATA_REN = m_ready;
                m_valid          = CHNL_TX_DATA_VALID;
                i_beat           = CHNL_TX_DATA_VALID & m_ready;
                if (i_beat && i_hit) begin
                    i_state_d = I_DONE;
                end
            end
            I_DONE: begin
                done_pulse = 1'b1;
                i_state_d  = I_IDLE;
            end
            default: i_state_d = I_IDLE;
        endcase
        if (i_state_d == I_DONE && i_state_q != I_DONE) begin
            done_len_d = i_len_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_state_q  <= O_IDLE;
            o_len_q    <= '0;
            o_off_q    <= '0;
            o_last_q   <= 1'b0;
            i_state_q  <= I_IDLE;
            i_len_q    <= '0;
            done_len_q <= '0;
            tx_armed_q <= 1'b1;
        end else begin
            o_state_q  <= o_state_d;
            o_len_q    <= o_len_d;
            o_off_q    <= o_off_d;
            o_last_q   <= o_last_d;
            i_state_q  <= i_state_d;
            i_len_q    <= i_len_d;
            done_len_q <= done_len_d;
            tx_armed_q <= tx_armed_d;
        end
    end

    assign CHNL_RX_LEN  = o_len_q;
    assign CHNL_RX_OFF  = o_off_q;
    assign CHNL_RX_LAST = o_last_q;
    assign CHNL_RX_DATA = s_data;
    assign m_data       = CHNL_TX_DATA;
    assign done_len     = done_len_q;

endmodule
